// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, divisor defaults and frame-length decode for the UART timing stage
package uart_pkg;

    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] DEF_DIV = 16'd433;
    localparam logic [DIV_W-1:0] MIN_DIV = 16'd3;

    typedef enum logic [1:0] {
        BITS5 = 2'd0,
        BITS6 = 2'd1,
        BITS7 = 2'd2,
        BITS8 = 2'd3
    } data_bits_e;

    function automatic logic [3:0] data_bits_to_n(input data_bits_e b);
        return {2'b00, b} + 4'd5;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: one channel's baud counter and saturating data-bit counter
module uart_bit_timer #(
    parameter int               DIV_W      = 16,
    parameter bit               HALF_FIRST = 1'b0,
    parameter logic [DIV_W-1:0] RST_DIV    = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             uart_en_i,
    input  logic             baud_en_i,
    input  logic             bit_en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [3:0]       n_i,
    output logic             tick_o,
    output logic             done_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d, idle_div;
    logic [3:0]       bits_q, bits_d;
    logic             run;

    // RX idles at half a period so its first tick samples mid start bit
    always_comb begin
        run      = uart_en_i & baud_en_i;
        idle_div = HALF_FIRST ? (div_i >> 1) : div_i;
        cnt_d    = !run ? idle_div : (cnt_q == '0) ? div_i : cnt_q - DIV_W'(1);
        bits_d   = !run ? 4'd0 : (bit_en_i && bits_q < n_i) ? bits_q + 4'd1 : bits_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= HALF_FIRST ? (RST_DIV >> 1) : RST_DIV;
            bits_q <= 4'd0;
        end else begin
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
        end
    end

    assign tick_o = run && (cnt_q == '0);
    assign done_o = uart_en_i && (bits_q == n_i);

endmodule

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: TX/RX baud ticks and data-bits-done flags with a frame-safe shadowed divisor
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int               DIV_W   = uart_pkg::DIV_W,
    parameter logic [DIV_W-1:0] DEF_DIV = uart_pkg::DEF_DIV,
    parameter logic [DIV_W-1:0] MIN_DIV = uart_pkg::MIN_DIV
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             uart_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             tx_baud_rate_reg_en,
    input  logic             tx_bit_count_reg_en,
    input  logic             rx_baud_rate_reg_en,
    input  logic             rx_bit_count_reg_en,
    output logic             tx_baud_rate,
    output logic             tx_bit_count,
    output logic             rx_baud_rate,
    output logic             rx_bit_count
);
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [3:0]       n;

    // Divisor only follows the CSR while neither channel is mid-frame
    always_comb begin
        shadow_d = (tx_baud_rate_reg_en || rx_baud_rate_reg_en) ? shadow_q :
                   (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
        n        = data_bits_to_n(data_bits_e'(data_bits));
    end

    always_ff @(posedge clock) begin
        if (reset) shadow_q <= DEF_DIV;
        else       shadow_q <= shadow_d;
    end

    uart_bit_timer #(.DIV_W(DIV_W), .HALF_FIRST(1'b0), .RST_DIV(DEF_DIV)) u_tx (
        .clock     (clock),
        .reset     (reset),
        .uart_en_i (uart_en),
        .baud_en_i (tx_baud_rate_reg_en),
        .bit_en_i  (tx_bit_count_reg_en),
        .div_i     (shadow_q),
        .n_i       (n),
        .tick_o    (tx_baud_rate),
        .done_o    (tx_bit_count)
    );

    uart_bit_timer #(.DIV_W(DIV_W), .HALF_FIRST(1'b1), .RST_DIV(DEF_DIV)) u_rx (
        .clock     (clock),
        .reset     (reset),
        .uart_en_i (uart_en),
        .baud_en_i (rx_baud_rate_reg_en),
        .bit_en_i  (rx_bit_count_reg_en),
        .div_i     (shadow_q),
        .n_i       (n),
        .tick_o    (rx_baud_rate),
        .done_o    (rx_bit_count)
    );

endmodule

// File: doc/uart_baud_timer.md
Name: uart_baud_timer

Overview:
- Timing stage directly upstream of the UART controller.
- Generates the per-bit baud ticks and the "all data bits done" flags for the TX and RX FSMs.
- Driven by the controller's baud/bit-count register enables.
- Holds a shadowed divisor so a CSR write never disturbs a frame in flight.

Parameters:
DIV_W, 16, width of baud divisor and baud counters
DEF_DIV, 16'd433, divisor loaded into the shadow register at reset (clocks per bit minus 1)
MIN_DIV, 3, smallest legal divisor; smaller programmed values are clamped up to it

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_en  input  1  block enable; 0 forces both channels idle/cleared
baud_div  input  DIV_W  programmed clocks-per-bit minus 1 (from CSR)
data_bits  input  2  frame data length: 0=5, 1=6, 2=7, 3=8 bits
tx_baud_rate_reg_en  input  1  TX baud counter run enable
tx_bit_count_reg_en  input  1  TX bit counter increment strobe
rx_baud_rate_reg_en  input  1  RX baud counter run enable
rx_bit_count_reg_en  input  1  RX bit counter increment strobe
tx_baud_rate  output  1  one-cycle TX bit-period tick
tx_bit_count  output  1  level: TX data bits complete
rx_baud_rate  output  1  one-cycle RX sample tick
rx_bit_count  output  1  level: RX data bits complete

Behaviour:
- Reset:
  - shadow_div <= DEF_DIV.
  - TX counter <= shadow_div; RX counter <= shadow_div>>1.
  - Both bit counters <= 0.
  - All outputs 0 in the cycle after reset.
- Shadow divisor:
  - shadow_div <= max(baud_div, MIN_DIV), only in cycles where both *_baud_rate_reg_en = 0.
  - Otherwise shadow_div holds its value, so it is frozen for the whole frame.
- TX baud counter (cnt_t):
  - If !uart_en or !tx_baud_rate_reg_en: cnt_t <= shadow_div.
  - Else if cnt_t == 0: cnt_t <= shadow_div.
  - Else: cnt_t <= cnt_t - 1.
  - tx_baud_rate = uart_en & tx_baud_rate_reg_en & (cnt_t == 0). Combinational from registered state.
  - First tick occurs in the (shadow_div+1)th enabled cycle; period thereafter is shadow_div+1.
- RX baud counter (cnt_r): identical to TX except the idle/disabled reload value is shadow_div>>1.
  - The first tick lands mid start bit, in the (shadow_div>>1)+1 th enabled cycle.
  - Every reload while enabled is shadow_div (full period).
- Bit counters (4 bits each):
  - Cleared while the matching baud enable is 0 or uart_en = 0.
  - Otherwise incremented on the matching bit_count_reg_en while count < N, where N = data_bits+5.
  - Saturate at N: further strobes are ignored.
- tx_bit_count / rx_bit_count = (count == N), decoded from registered state.
- data_bits changes mid-frame take effect immediately on the compare.
  - If the count already exceeds the new N, the flag stays 0 until the counter is cleared. This is software misuse, not trapped.
- Simultaneous events:
  - Baud enable falling in the same cycle as a tick: the tick is still visible that cycle; the counter reloads next cycle.
  - Bit strobe in the same cycle the baud enable drops: the clear wins.
- uart_en low mid-frame: same as all enables low; outputs 0 immediately (combinational gating); counters reload next edge.
- Reset mid-frame: all state returns to its reset values; shadow_div returns to DEF_DIV.
- TX and RX channels are fully independent; both may run concurrently sharing shadow_div.

Decomposition:
- Package uart_pkg: DIV_W, MIN_DIV, DEF_DIV, a data_bits_e enum (BITS5..BITS8), and a function data_bits_to_n().
- Sub-module uart_bit_timer (parameter HALF_FIRST) holds one baud counter plus one bit counter.
  - Instantiated twice: TX with HALF_FIRST=0, RX with HALF_FIRST=1.
  - The shadow register and clamp live in the top level.

Test Plan:
1. baud_div=9, hold tx_baud_rate_reg_en=1 for 30 cycles -> tx_baud_rate high in enabled cycles 10, 20, 30 only.
2. baud_div=9, rx_baud_rate_reg_en=1 for 30 cycles -> rx_baud_rate high in cycles 5, 15, 25.
3. data_bits=3, tx enable on, 8 tx_bit_count_reg_en strobes -> tx_bit_count rises after the 8th and holds through a 9th; repeat with data_bits=0 -> rises after the 5th.
4. baud_div 9->19 written while tx enabled -> period stays 10 until both enables drop for a cycle; next frame period is 20.
5. Mid-frame (after 3 ticks, bit count 3), pulse reset or drop uart_en -> ticks and flags 0 that cycle; counters reloaded/zeroed; restart gives the first tick at cycle 10 again.
6. baud_div=1 -> clamped to 3: TX period 4; RX first tick in cycle 2, then every 4 cycles.
